// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end fetch stage of the RV32I core. It owns the architectural fetch PC,
// requests instruction words from instruction memory over a req/ack handshake,
// and hands each fetched instruction plus its address to decode through a
// single-entry valid/ready slot. Branch/jump redirects and halts are applied
// when decode consumes the instruction that caused them.
//
// Ports:
//   CLK, RST        core clock (rising edge), asynchronous active-high reset
//   IMem_Req        fetch request to instruction memory
//   IMem_Addr       word-aligned fetch address
//   IMem_Ack        memory returns IMem_RData this cycle (only meaningful with Req)
//   IMem_RData      instruction word from memory
//   Instr, PC       registered instruction and its address, presented to decode
//   PCPlus4         PC + 4 (combinational, wraps mod 2^32)
//   Instr_Valid     Instr/PC hold a live instruction
//   Instr_Ready     decode consumes Instr this cycle
//   PCSrc, PCTarget redirect request/address for the consumed instruction
//   Halt            consumed instruction stops the core (ecall/ebreak/fatal)
//   Fetch_Err       sticky: a redirect target was not word-aligned
//   Halted          fetch permanently stopped until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            IMem_Req,
    output logic [XLEN-1:0] IMem_Addr,
    input  logic            IMem_Ack,
    input  logic [XLEN-1:0] IMem_RData,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            Instr_Valid,
    input  logic            Instr_Ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            Halt,
    output logic            Fetch_Err,
    output logic            Halted
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [XLEN-1:0] fetch_pc;
    logic            consume;
    logic            accept;
    logic            target_misaligned;

    assign consume           = Instr_Valid & Instr_Ready;
    assign accept            = IMem_Req & IMem_Ack;
    assign target_misaligned = (PCTarget[1:0] != 2'b00);
    assign IMem_Addr         = fetch_pc;
    assign PCPlus4           = PC + XLEN'(4);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. A request is only raised when the slot
    // is empty or is being drained this cycle by a plain (non-redirect,
    // non-halt) consume; that keeps Req/Addr stable while waiting on memory,
    // and guarantees nothing is in flight when a redirect or halt lands.
    always_comb begin
        next_state = state;
        IMem_Req   = 1'b0;
        Halted     = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                IMem_Req = !Instr_Valid | (consume & !PCSrc & !Halt);
                if (consume && (Halt || (PCSrc && target_misaligned))) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                Halted = 1'b1;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // Fetch PC, instruction slot and error flag. Redirect/halt on consume
    // takes priority; when it applies, IMem_Req is low, so no accept can
    // coincide with it. A consume that coincides with an accept simply
    // overwrites the slot, giving one instruction per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            Instr_Valid <= 1'b0;
            Fetch_Err   <= 1'b0;
        end else if (state == RUN) begin
            if (consume && (Halt || PCSrc)) begin
                Instr_Valid <= 1'b0;
                if (!Halt) begin
                    if (target_misaligned) begin
                        Fetch_Err <= 1'b1;
                    end else begin
                        fetch_pc <= PCTarget;
                    end
                end
            end else if (accept) begin
                Instr       <= IMem_RData;
                PC          <= fetch_pc;
                Instr_Valid <= 1'b1;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end else if (consume) begin
                Instr_Valid <= 1'b0;
            end
        end
    end

endmodule
